ex_mem_req: RTL

Parametrised load/store request unit for the EX stage, the successor to the fixed 32-bit direct-SRAM store path. Takes one memory op per handshake from EX and generates the byte strobes, write data and misalignment check. It issues the op on the class-SRAM request bus (req/addr_ok, data_ok) and tracks up to MAX_OUTSTANDING in-flight requests in order. On each data_ok it returns the aligned, sign/zero-extended load result to MEM, and discards responses belonging to flushed ops.

---
 rtl/mycpu_pkg.sv | 42 ++++
 rtl/mem_meta_fifo.sv | 61 ++++++
 rtl/ex_mem_req.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mycpu_pkg.sv
// Shared memory-op definitions: access size encodings, metadata record layout
// and the misalignment rule used by the load/store request path.
package mycpu_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_D = 2'd3
  } mem_size_e;

  localparam int OFF_W = 3;

  // Per-op fields carried from request to response. The queue entry is
  // {tag, meta_op_t, cancelled}; cancelled always lives in bit 0.
  typedef struct packed {
    logic             we;
    logic [1:0]       size;
    logic             uns;
    logic [OFF_W-1:0] off;
  } meta_op_t;

  localparam int META_OP_W = $bits(meta_op_t);

  function automatic int meta_w(input int tag_w);
    return tag_w + META_OP_W + 1;
  endfunction

  // A double access can only be aligned on a 64-bit bus.
  function automatic logic mem_ale(input logic [1:0] size, input logic [2:0] off,
                                   input logic wide);
    logic mis;
    case (size)
      SIZE_B:  mis = 1'b0;
      SIZE_H:  mis = off[0];
      SIZE_W:  mis = (off[1:0] != 2'b00);
      default: mis = ~wide | (off != 3'b000);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_meta_fifo.sv
// In-order FIFO for in-flight request metadata, with a broadcast that marks
// every stored entry (bit 0) as cancelled.
module mem_meta_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             cancel_all,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head,
  output logic [3:0]       count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [3:0]       cnt;
  logic             push_ok, pop_ok;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (cnt == 4'(DEPTH));
  assign empty   = (cnt == 4'd0);
  assign count   = cnt;
  assign head    = mem[rd_ptr];
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= next_ptr(wr_ptr);
      if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 4'd1;
        2'b01:   cnt <= cnt - 4'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (cancel_all) begin
      for (int i = 0; i < DEPTH; i++) mem[i][0] <= 1'b1;
    end
    if (push_ok) mem[wr_ptr] <= {push_data[WIDTH-1:1], push_data[0] | cancel_all};
  end

endmodule

// File: rtl/ex_mem_req.sv
// EX-stage load/store request unit: issues one op at a time on the SRAM-like
// request bus, tracks in-flight ops in order and returns aligned load data.
//
// state  | meaning
// S_IDLE | request register empty
// S_REQ  | req high, registered op held stable until addr_ok
module ex_mem_req
  import mycpu_pkg::*;
#(
  parameter int DATA_W          = 32,
  parameter int ADDR_W          = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int TAG_W           = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [DATA_W-1:0]   in_wdata,
  input  logic [1:0]          in_size,
  input  logic                in_we,
  input  logic                in_unsigned,
  input  logic [TAG_W-1:0]    in_tag,
  input  logic                in_excep,
  input  logic                flush,
  output logic                ale,
  output logic                req,
  output logic                wr,
  output logic [1:0]          size,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   wdata,
  input  logic                addr_ok,
  input  logic                data_ok,
  input  logic [DATA_W-1:0]   rdata,
  output logic                resp_valid,
  output logic                resp_is_store,
  output logic [TAG_W-1:0]    resp_tag,
  output logic [DATA_W-1:0]   resp_data
);

  localparam int   STRB_W  = DATA_W / 8;
  localparam logic WIDE    = (DATA_W == 64);
  localparam int   ENTRY_W = meta_w(TAG_W);

  typedef enum logic {S_IDLE, S_REQ} state_e;

  state_e              state;
  logic [TAG_W-1:0]    r_tag;
  logic                r_uns;
  logic                r_cancel;

  logic                mis, accept, issue, pop;
  logic [2:0]          in_off, req_off;
  logic [4:0]          outstanding;
  logic [STRB_W-1:0]   strb_nxt;
  logic [DATA_W-1:0]   wdata_nxt;

  logic                fifo_push, fifo_full, fifo_empty;
  logic [3:0]          fifo_cnt;
  logic [ENTRY_W-1:0]  push_entry, head;
  meta_op_t            push_op, head_op;
  logic [TAG_W-1:0]    head_tag;
  logic                head_cancel;

  logic [DATA_W-1:0]   shifted, ext;
  logic                sgn_b, sgn_h, sgn_w;

  assign in_off  = WIDE ? in_addr[2:0] : {1'b0, in_addr[1:0]};
  assign req_off = WIDE ? addr[2:0]    : {1'b0, addr[1:0]};
  assign mis     = mem_ale(in_size, in_addr[2:0], WIDE);
  assign ale     = ~reset & in_valid & mis;

  // A data_ok pop frees a slot in the same cycle, so admission can reopen then.
  assign pop         = data_ok & ~fifo_empty;
  assign outstanding = {1'b0, fifo_cnt} + {4'b0, (state == S_REQ)};
  assign in_ready    = ~reset & ~flush & ((state == S_IDLE) | addr_ok)
                     & ((outstanding - {4'b0, pop}) < 5'(MAX_OUTSTANDING))
                     & (~fifo_full | pop);
  assign accept      = in_valid & in_ready;
  assign issue       = accept & ~mis & ~in_excep;

  always_comb begin
    strb_nxt  = '0;
    wdata_nxt = '0;
    case (in_size)
      SIZE_B: begin
        strb_nxt  = STRB_W'(1) << in_off;
        wdata_nxt = {(DATA_W/8){in_wdata[7:0]}};
      end
      SIZE_H: begin
        strb_nxt  = STRB_W'(2'b11) << in_off;
        wdata_nxt = {(DATA_W/16){in_wdata[15:0]}};
      end
      SIZE_W: begin
        strb_nxt  = STRB_W'(4'hF) << in_off;
        wdata_nxt = {(DATA_W/32){in_wdata[31:0]}};
      end
      default: begin
        strb_nxt  = '1;
        wdata_nxt = in_wdata;
      end
    endcase
    if (!in_we) strb_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      wr       <= 1'b0;
      size     <= '0;
      addr     <= '0;
      wstrb    <= '0;
      wdata    <= '0;
      r_tag    <= '0;
      r_uns    <= 1'b0;
      r_cancel <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (issue) begin
            state    <= S_REQ;
            wr       <= in_we;
            size     <= in_size;
            addr     <= in_addr;
            wstrb    <= strb_nxt;
            wdata    <= wdata_nxt;
            r_tag    <= in_tag;
            r_uns    <= in_unsigned;
            r_cancel <= 1'b0;
          end
        end
        S_REQ: begin
          if (addr_ok) begin
            if (issue) begin
              wr       <= in_we;
              size     <= in_size;
              addr     <= in_addr;
              wstrb    <= strb_nxt;
              wdata    <= wdata_nxt;
              r_tag    <= in_tag;
              r_uns    <= in_unsigned;
              r_cancel <= 1'b0;
            end else begin
              state <= S_IDLE;
            end
          end else if (flush) begin
            // The request cannot be withdrawn; it completes and is dropped later.
            r_cancel <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign req = (state == S_REQ);

  always_comb begin
    push_op      = '0;
    push_op.we   = wr;
    push_op.size = size;
    push_op.uns  = r_uns;
    push_op.off  = req_off;
  end

  assign fifo_push  = req & addr_ok;
  assign push_entry = {r_tag, push_op, r_cancel | flush};

  mem_meta_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_meta_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (fifo_push),
    .push_data  (push_entry),
    .pop        (pop),
    .cancel_all (flush),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head       (head),
    .count      (fifo_cnt)
  );

  assign head_tag    = head[ENTRY_W-1 -: TAG_W];
  assign head_op     = head[META_OP_W:1];
  assign head_cancel = head[0];

  assign shifted = rdata >> {head_op.off, 3'b000};
  assign sgn_b   = ~head_op.uns & shifted[7];
  assign sgn_h   = ~head_op.uns & shifted[15];
  assign sgn_w   = ~head_op.uns & shifted[31];

  always_comb begin
    ext = shifted;
    case (head_op.size)
      SIZE_B: begin
        ext       = {DATA_W{sgn_b}};
        ext[7:0]  = shifted[7:0];
      end
      SIZE_H: begin
        ext       = {DATA_W{sgn_h}};
        ext[15:0] = shifted[15:0];
      end
      SIZE_W: begin
        ext       = {DATA_W{sgn_w}};
        ext[31:0] = shifted[31:0];
      end
      default: ext = shifted;
    endcase
  end

  assign resp_valid    = pop & ~head_cancel;
  assign resp_is_store = resp_valid & head_op.we;
  assign resp_tag      = resp_valid ? head_tag : '0;
  assign resp_data     = (resp_valid & ~head_op.we) ? ext : '0;

endmodule
